mem_read_sched: RTL and testbench
=================================

Name: mem_read_sched

Overview:
- Sequences the single shared SRAM read port among NUM_PORTS egress memory read controllers.
- Grants frame-length bursts in round-robin order, with a burst cap to prevent starvation and a per-port outstanding-read limit that acts as TX-FIFO credit.
- Tracks in-flight reads with a port tag FIFO and steers each returned block to the port that issued it.
- Sits between the egress memory read controllers and the sram read port, in the switch_clk domain.

Parameters:
NUM_PORTS, switch_pkg::NUM_PORTS, number of egress requesters
ADDR_W, mem_pkg::ADDR_W, SRAM block address width
BLOCK_BITS, mem_pkg::BLOCK_BITS, SRAM block data width
MAX_BURST, 8, maximum consecutive grants to one owner before forced rotation
MAX_OUTST, 4, maximum in-flight reads per port
TAG_DEPTH, 4, tag FIFO depth; must be at least the SRAM read latency plus 1

Ports:
switch_clk  in  1  clock
switch_rst_n  in  1  asynchronous active-low reset
req_i  in  1 [NUM_PORTS]  port wants to read a block
raddr_i  in  ADDR_W [NUM_PORTS]  block address to read
last_i  in  1 [NUM_PORTS]  current request is the final block of the frame
gnt_o  out  1 [NUM_PORTS]  read issued this cycle; requester advances its address
mem_re_o  out  1  SRAM read enable
mem_raddr_o  out  ADDR_W  SRAM read address
mem_rvalid_i  in  1  SRAM read data valid
mem_rdata_i  in  BLOCK_BITS  SRAM read data
rvalid_o  out  1 [NUM_PORTS]  returned block valid for this port
rdata_o  out  BLOCK_BITS  returned block, shared by all ports
err_o  out  1  sticky: rvalid received with no tag outstanding

Behaviour:
- One clock, switch_clk. Reset switch_rst_n is asynchronous, active-low.
- Reset values:
  - FSM = IDLE; rr_ptr = 0; owner = 0; burst_cnt = 0.
  - Outstanding counters = 0; tag FIFO empty.
  - gnt_o, mem_re_o, rvalid_o, err_o = 0; mem_raddr_o = 0; rdata_o = 0.
- Eligibility: port p is eligible when req_i[p]=1 and outst[p] < MAX_OUTST.
- Issue is blocked globally while the tag FIFO is full.
- FSM IDLE:
  - No grant is issued.
  - If any port is eligible, owner <= the first eligible port scanning from rr_ptr upward, with wrap-around.
  - burst_cnt <= 0; next state BURST.
  - Arbitration costs one bubble cycle per burst.
- FSM BURST, issue case (owner eligible and tag FIFO not full):
  - gnt_o[owner] = 1, mem_re_o = 1, mem_raddr_o = raddr_i[owner]. These are combinational from registered state.
  - Push owner onto the tag FIFO; outst[owner] += 1; burst_cnt += 1.
  - End the burst if last_i[owner]=1 or burst_cnt == MAX_BURST-1.
- FSM BURST, stall case:
  - If req_i[owner]=0, end the burst.
  - If owner is blocked by credit or a full tag FIFO while req_i[owner]=1, stay in BURST without issuing.
- Ending a burst: next state IDLE; rr_ptr <= owner+1, modulo NUM_PORTS.
- Only gnt_o[owner] can ever be 1, so at most one bit of gnt_o is set. mem_raddr_o = 0 whenever mem_re_o = 0.
- Return path:
  - On mem_rvalid_i with the FIFO non-empty: pop tag t.
  - Next cycle: rvalid_o[t] = 1 and rdata_o = the captured mem_rdata_i (registered, 1-cycle latency).
  - outst[t] -= 1 in the same cycle as the pop.
  - rdata_o holds its value when no data is returned.
- Return path error: on mem_rvalid_i with the FIFO empty, set err_o (sticky until reset), drop the data and leave rvalid_o = 0.
- Simultaneous events:
  - Push and pop in the same cycle are both performed; FIFO occupancy is unchanged.
  - Issue and return on the same port in the same cycle leave outst unchanged.
  - A full FIFO with a same-cycle pop still blocks issue, so the full check is on registered occupancy.
- Counter widths: $clog2(MAX_OUTST+1) for outst and $clog2(MAX_BURST) for burst_cnt. Neither counter may wrap.
- Reset asserted mid-burst or with reads in flight: all state clears. SRAM returns arriving after reset raise err_o; they are never delivered to a port.

Decomposition:
- mem_pkg: add typedef sched_state_e {IDLE, BURST}, constants MAX_BURST and MAX_OUTST, and typedef port_idx_t = logic [$clog2(NUM_PORTS)-1:0].
- Sub-module rd_tag_fifo: synchronous FIFO of port_idx_t, depth TAG_DEPTH, with push, pop, full, empty and count. It is instantiated once.
- Round-robin selection is a function in mem_pkg.

Test Plan:
- Port 2 only, 3-block frame (last_i on 3rd beat), SRAM latency 2:
  - Port 2 is selected in the IDLE cycle and gnt_o[2] pulses on the next 3 cycles.
  - rvalid_o[2] pulses 3 times, each 3 cycles after the matching grant.
  - FSM returns to IDLE and rr_ptr = 3.
- All 4 ports requesting 1-block frames:
  - Grant order 0,1,2,3,0 with one idle cycle between bursts.
  - Every rvalid_o matches its issuing port.
- Port 1 streams 20 blocks without last_i, port 0 also requesting:
  - Port 1 gets exactly 8 grants, then port 0 is served.
  - Port 1 resumes after port 0's burst ends.
- SRAM rvalid held off, port 0 requesting continuously (MAX_OUTST=4):
  - Exactly 4 grants, then gnt_o[0]=0 with the FSM holding BURST.
  - One return re-enables exactly one further grant.
- mem_rvalid_i pulsed with nothing in flight: err_o=1 and stays 1; no rvalid_o bit asserts.
- switch_rst_n asserted mid-burst with 2 reads in flight:
  - All outputs go to 0 asynchronously.
  - Both late returns set err_o and produce no rvalid_o.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared SRAM geometry, read scheduler types and round-robin pick
package mem_pkg;
   localparam int unsigned ADDR_W     = 12;
   localparam int unsigned BLOCK_BITS = 32;
   localparam int unsigned MAX_BURST  = 8;
   localparam int unsigned MAX_OUTST  = 4;
   localparam int unsigned PORT_IDX_W =
      (switch_pkg::NUM_PORTS > 1) ? $clog2(switch_pkg::NUM_PORTS) : 1;

   typedef logic [PORT_IDX_W-1:0] port_idx_t;
   typedef enum logic {IDLE, BURST} sched_state_e;

   // First set bit of elig at or above ptr, wrapping; scanned downward so the
   // closest candidate is written last and wins.
   function automatic port_idx_t rr_pick(input logic [switch_pkg::NUM_PORTS-1:0] elig,
                                         input port_idx_t ptr);
      port_idx_t pick;
      port_idx_t idx;
      pick = ptr;
      for (int i = int'(switch_pkg::NUM_PORTS) - 1; i >= 0; i--) begin
         idx = port_idx_t'((int'(ptr) + i) % int'(switch_pkg::NUM_PORTS));
         if (elig[idx]) pick = idx;
      end
      return pick;
   endfunction
endpackage

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - switch-wide constants shared by ingress and egress blocks
package switch_pkg;
   localparam int unsigned NUM_PORTS = 4;
endpackage

// File: rtl/rd_tag_fifo.sv
// rtl/rd_tag_fifo.sv - in-order FIFO of issuing-port tags for in-flight SRAM reads
module rd_tag_fifo
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH + 1),
   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  port_idx_t     din,
   input  logic          pop,
   output port_idx_t     dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   port_idx_t     mem_q [DEPTH];
   port_idx_t     mem_d [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      do_push = push && (count_q != CW'(DEPTH));
      do_pop  = pop && (count_q != '0);
      if (do_push) begin
         mem_d[wptr_q] = din;
         wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (do_pop) rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign dout  = mem_q[rptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
endmodule

// File: rtl/mem_read_sched.sv
// rtl/mem_read_sched.sv - round-robin burst scheduler for the shared SRAM read port
module mem_read_sched
   import mem_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = switch_pkg::NUM_PORTS,
   parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
   parameter int unsigned BLOCK_BITS = mem_pkg::BLOCK_BITS,
   parameter int unsigned MAX_BURST  = mem_pkg::MAX_BURST,
   parameter int unsigned MAX_OUTST  = mem_pkg::MAX_OUTST,
   parameter int unsigned TAG_DEPTH  = 4
) (
   input  logic                        switch_clk,
   input  logic                        switch_rst_n,
   input  logic [NUM_PORTS-1:0]        req_i,
   input  logic [NUM_PORTS*ADDR_W-1:0] raddr_i,
   input  logic [NUM_PORTS-1:0]        last_i,
   output logic [NUM_PORTS-1:0]        gnt_o,
   output logic                        mem_re_o,
   output logic [ADDR_W-1:0]           mem_raddr_o,
   input  logic                        mem_rvalid_i,
   input  logic [BLOCK_BITS-1:0]       mem_rdata_i,
   output logic [NUM_PORTS-1:0]        rvalid_o,
   output logic [BLOCK_BITS-1:0]       rdata_o,
   output logic                        err_o
);
   localparam int unsigned OW  = $clog2(MAX_OUTST + 1);
   localparam int unsigned BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int unsigned TCW = $clog2(TAG_DEPTH + 1);

   sched_state_e          state_q, state_d;
   port_idx_t             owner_q, owner_d, rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
   logic [OW-1:0]         outst_q [NUM_PORTS];
   logic [OW-1:0]         outst_d [NUM_PORTS];
   logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
   logic [BLOCK_BITS-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [NUM_PORTS-1:0]  elig;
   logic                  issue, pop, end_burst;
   logic                  tag_full, tag_empty;
   port_idx_t             tag_dout;
   logic [TCW-1:0]        tag_count;

   rd_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
      .clk   (switch_clk),
      .rst_n (switch_rst_n),
      .push  (issue),
      .din   (owner_q),
      .pop   (pop),
      .dout  (tag_dout),
      .full  (tag_full),
      .empty (tag_empty),
      .count (tag_count)
   );

   // Full is checked on registered occupancy, so a same-cycle pop never frees a slot early.
   always_comb begin
      for (int p = 0; p < int'(NUM_PORTS); p++)
         elig[p] = req_i[p] && (outst_q[p] < OW'(MAX_OUTST));
      issue = (state_q == BURST) && elig[owner_q] && !tag_full;
      pop   = mem_rvalid_i && !tag_empty;
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      end_burst   = 1'b0;
      case (state_q)
         IDLE: begin
            burst_cnt_d = '0;
            if (|elig) begin
               owner_d = rr_pick(elig, rr_ptr_q);
               state_d = BURST;
            end
         end
         BURST: begin
            if (issue) begin
               burst_cnt_d = burst_cnt_q + BW'(1);
               if (last_i[owner_q] || (burst_cnt_q == BW'(MAX_BURST - 1))) end_burst = 1'b1;
            end else if (!req_i[owner_q]) begin
               end_burst = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (end_burst) begin
         state_d     = IDLE;
         burst_cnt_d = '0;
         rr_ptr_d    = (owner_q == port_idx_t'(NUM_PORTS - 1)) ? '0 : owner_q + port_idx_t'(1);
      end
   end

   always_comb begin
      gnt_o = '0;
      if (issue) gnt_o[owner_q] = 1'b1;
      mem_re_o    = issue;
      mem_raddr_o = issue ? raddr_i[owner_q*ADDR_W +: ADDR_W] : '0;

      rvalid_d = '0;
      rdata_d  = rdata_q;
      if (pop) begin
         rvalid_d[tag_dout] = 1'b1;
         rdata_d            = mem_rdata_i;
      end
      err_d = err_q | (mem_rvalid_i && (tag_count == '0));

      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         outst_d[p] = outst_q[p];
         if (issue && (owner_q == port_idx_t'(p))) outst_d[p] = outst_d[p] + OW'(1);
         if (pop && (tag_dout == port_idx_t'(p)))  outst_d[p] = outst_d[p] - OW'(1);
      end
   end

   always_ff @(posedge switch_clk or negedge switch_rst_n) begin
      if (!switch_rst_n) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         outst_q     <= '{default: '0};
         rvalid_q    <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         outst_q     <= outst_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
endmodule

// File: tb/tb_mem_read_sched.sv
// tb/tb_mem_read_sched.sv - scoreboard bench for mem_read_sched with requester and SRAM models
module tb_mem_read_sched;
   import mem_pkg::*;
   localparam int NP = int'(switch_pkg::NUM_PORTS);
   localparam int AW = int'(ADDR_W);
   localparam int BB = int'(BLOCK_BITS);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NP-1:0]    req = '0;
   logic [NP*AW-1:0] raddr = '0;
   logic [NP-1:0]    last = '0;
   logic [NP-1:0]    gnt;
   logic             mem_re;
   logic [AW-1:0]    mem_raddr;
   logic             mem_rvalid = 1'b0;
   logic [BB-1:0]    mem_rdata = '0;
   logic [NP-1:0]    rvalid;
   logic [BB-1:0]    rdata;
   logic             err;

   always #5 clk = ~clk;

   mem_read_sched dut (
      .switch_clk   (clk),
      .switch_rst_n (rst_n),
      .req_i        (req),
      .raddr_i      (raddr),
      .last_i       (last),
      .gnt_o        (gnt),
      .mem_re_o     (mem_re),
      .mem_raddr_o  (mem_raddr),
      .mem_rvalid_i (mem_rvalid),
      .mem_rdata_i  (mem_rdata),
      .rvalid_o     (rvalid),
      .rdata_o      (rdata),
      .err_o        (err)
   );

   int errors = 0;
   int checks = 0;

   // Requester model: mode 0 = last on final block, 1 = every block is a frame, 2 = never last
   int            rem [NP];
   int            mode [NP];
   logic [AW-1:0] addr [NP];
   int  cyc = 0, last_gnt_cyc = -100, gnt_seen = 0;
   bit  hold = 0, chk_lat = 0;
   int  rel_req = 0, rel_used = 0, inj_req = 0, inj_done = 0;

   int            exp_gp [$];
   int            exp_gap [$];
   int            exp_rp [$];
   int            exp_rc [$];
   logic [BB-1:0] exp_rd [$];
   logic [AW-1:0] pend_a [$];
   int            pend_r [$];

   function automatic logic [BB-1:0] blk(input logic [AW-1:0] a);
      return {a, 8'h3C, a};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      for (int p = 0; p < NP; p++) begin
         rem[p] = 0; mode[p] = 0; addr[p] = '0;
      end
   end

   // Monitor + requester + SRAM model (latency 2, optional hold-off)
   initial begin
      logic [NP-1:0] g;
      int p, ep, eg, ec;
      logic [BB-1:0] ed;
      forever begin
         @(negedge clk);
         g = gnt;
         if (gnt != '0) begin
            p = 0;
            for (int i = 0; i < NP; i++) if (gnt[i]) p = i;
            check("gnt_onehot", 64'($countones(gnt)), 64'd1);
            if (exp_gp.size() == 0) begin
               check("gnt_unexpected", 64'(gnt), 64'd0);
            end else begin
               ep = exp_gp.pop_front();
               eg = exp_gap.pop_front();
               check("gnt_port", 64'(p), 64'(ep));
               if (eg > 0) check("gnt_gap", 64'(cyc - last_gnt_cyc), 64'(eg));
               check("gnt_addr", 64'(mem_raddr), 64'(addr[ep]));
               exp_rp.push_back(ep);
               exp_rd.push_back(blk(addr[ep]));
               exp_rc.push_back(chk_lat ? cyc + 3 : -1);
            end
            last_gnt_cyc = cyc;
            gnt_seen++;
         end
         if (mem_re) begin
            pend_a.push_back(mem_raddr);
            pend_r.push_back(cyc + 2);
         end
         if (rvalid != '0) begin
            if (exp_rp.size() == 0) begin
               check("rvalid_unexpected", 64'(rvalid), 64'd0);
            end else begin
               ep = exp_rp.pop_front();
               ed = exp_rd.pop_front();
               ec = exp_rc.pop_front();
               check("rvalid_port", 64'(rvalid), 64'(1) << ep);
               check("rdata", 64'(rdata), 64'(ed));
               if (ec >= 0) check("rvalid_lat", 64'(cyc), 64'(ec));
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < NP; i++) begin
            if (g[i] && rem[i] > 0) begin
               rem[i]--;
               addr[i]++;
            end
            req[i] = (rem[i] > 0);
            raddr[i*AW +: AW] = addr[i];
            last[i] = (mode[i] == 1) || (mode[i] == 0 && rem[i] == 1);
         end
         mem_rvalid = 1'b0;
         if (inj_done < inj_req) begin
            inj_done++;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
         end else if (pend_a.size() > 0 && pend_r[0] <= cyc && (!hold || rel_used < rel_req)) begin
            if (hold) rel_used++;
            mem_rvalid = 1'b1;
            mem_rdata  = blk(pend_a.pop_front());
            void'(pend_r.pop_front());
         end
      end
   end

   task automatic load(input int p, input int n, input int m, input logic [AW-1:0] a);
      rem[p] = n; mode[p] = m; addr[p] = a;
   endtask

   task automatic push_g(input int p, input int gap);
      exp_gp.push_back(p);
      exp_gap.push_back(gap);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic end_test(input string name);
      check({name, "_grants_left"}, 64'(exp_gp.size()), 64'd0);
      check({name, "_returns_left"}, 64'(exp_rp.size()), 64'd0);
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_gnt"}, 64'(gnt), 64'd0);
      check({name, "_mem_re"}, 64'(mem_re), 64'd0);
      check({name, "_mem_raddr"}, 64'(mem_raddr), 64'd0);
      check({name, "_rvalid"}, 64'(rvalid), 64'd0);
      check({name, "_rdata"}, 64'(rdata), 64'd0);
      check({name, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      wait_cyc(3);
      check_zero_outputs("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      // Port 2 alone, 3-block frame
      @(negedge clk);
      chk_lat = 1;
      load(2, 3, 0, 12'h100);
      push_g(2, 0); push_g(2, 1); push_g(2, 1);
      wait_cyc(12);
      end_test("t1");

      // All ports, 1-block frames; rr_ptr left at 3 so port 3 goes first
      load(0, 1, 0, 12'h200); load(1, 1, 0, 12'h210);
      load(2, 1, 0, 12'h220); load(3, 1, 0, 12'h230);
      push_g(3, 0); push_g(0, 2); push_g(1, 2); push_g(2, 2);
      wait_cyc(20);
      end_test("t2");

      // After reset rr_ptr=0: order 0,1,2,3,0
      rst_n = 1'b0;
      wait_cyc(2);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      load(0, 2, 1, 12'h240); load(1, 1, 0, 12'h250);
      load(2, 1, 0, 12'h260); load(3, 1, 0, 12'h270);
      push_g(0, 0); push_g(1, 2); push_g(2, 2); push_g(3, 2); push_g(0, 2);
      wait_cyc(25);
      end_test("t3");

      // Burst cap: port 1 streams 20 without last, port 0 has a 2-block frame
      load(1, 20, 2, 12'h300); load(0, 2, 0, 12'h380);
      for (int i = 0; i < 8; i++) push_g(1, (i == 0) ? 0 : 1);
      push_g(0, 2); push_g(0, 1);
      for (int i = 0; i < 8; i++) push_g(1, (i == 0) ? 2 : 1);
      for (int i = 0; i < 4; i++) push_g(1, (i == 0) ? 2 : 1);
      wait_cyc(60);
      end_test("t4");

      // Credit limit with SRAM returns held off
      chk_lat = 0;
      hold = 1;
      load(0, 10, 2, 12'h400);
      push_g(0, 0); push_g(0, 1); push_g(0, 1); push_g(0, 1);
      wait_cyc(15);
      check("t5_four_grants", 64'(exp_gp.size()), 64'd0);
      push_g(0, 0);
      rel_req++;
      wait_cyc(10);
      check("t5_one_more_grant", 64'(exp_gp.size()), 64'd0);
      for (int i = 0; i < 5; i++) push_g(0, 0);
      hold = 0;
      wait_cyc(40);
      end_test("t5");

      // Return with nothing in flight
      inj_req++;
      wait_cyc(3);
      check("t6_err_set", 64'(err), 64'd1);
      wait_cyc(5);
      check("t6_err_sticky", 64'(err), 64'd1);

      // Reset with two reads in flight
      hold = 1;
      load(3, 6, 2, 12'h500);
      push_g(3, 0); push_g(3, 1);
      base = gnt_seen;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #2;
         if (gnt_seen >= base + 2) break;
      end
      check("t7_two_grants_seen", 64'(gnt_seen >= base + 2), 64'd1);
      rst_n = 1'b0;
      rem[3] = 0;
      #1;
      check_zero_outputs("t7_async_reset");
      exp_rp.delete(); exp_rd.delete(); exp_rc.delete();
      wait_cyc(2);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      hold = 0;
      wait_cyc(6);
      check("t7_late_returns_done", 64'(pend_a.size()), 64'd0);
      check("t7_err_after_late", 64'(err), 64'd1);
      check("t7_no_rvalid", 64'(rvalid), 64'd0);
      end_test("t7");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
